pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl.sv | 115 +++++++++++
 tb/tb_pc_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Program counter controller with branch/jump/return redirection,
// exception capture and a circular return-address stack.
module pc_ctrl #(
    parameter int unsigned          ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0]    EXC_VECTOR   = ADDR_W'(32'h0000_0080),
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic              pc_ctrl_clk,
    input  logic              pc_ctrl_rst,
    input  logic              pc_ctrl_stall,
    input  logic              pc_ctrl_exc,
    input  logic              pc_ctrl_branch,
    input  logic              pc_ctrl_jmp,
    input  logic              pc_ctrl_jal,
    input  logic              pc_ctrl_ret,
    input  logic [ADDR_W-1:0] pc_ctrl_offset_addr,
    input  logic [ADDR_W-1:0] pc_ctrl_jr_target,
    output logic [ADDR_W-1:0] pc_ctrl_out,
    output logic [ADDR_W-1:0] pc_ctrl_epc,
    output logic [4:0]        pc_ctrl_ras_count,
    output logic              pc_ctrl_ras_miss
);

    localparam int unsigned PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W-1:0] TOP_MAX = PTR_W'(RAS_DEPTH - 1);
    localparam logic [4:0]  DEPTH_C = 5'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]  top_q, top_d;
    logic              miss_q, miss_d;
    logic              push;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [PTR_W-1:0]  top_inc;
    logic [PTR_W-1:0]  top_dec;

    always_comb begin
        pc4     = pc_q + ADDR_W'(4);
        br_tgt  = pc4 + (pc_ctrl_offset_addr << 2);
        jmp_tgt = {pc4[ADDR_W-1:28], pc_ctrl_offset_addr[25:0], 2'b00};
        top_inc = (top_q == TOP_MAX) ? '0 : top_q + PTR_W'(1);
        top_dec = (top_q == '0) ? TOP_MAX : top_q - PTR_W'(1);
    end

    always_comb begin
        pc_d   = pc4;
        epc_d  = epc_q;
        cnt_d  = cnt_q;
        top_d  = top_q;
        miss_d = 1'b0;
        push   = 1'b0;
        if (pc_ctrl_exc) begin
            pc_d  = EXC_VECTOR;
            epc_d = pc_q;
        end else if (pc_ctrl_stall) begin
            pc_d = pc_q;
        end else if (pc_ctrl_branch) begin
            pc_d = br_tgt;
        end else if (pc_ctrl_jmp || pc_ctrl_jal) begin
            pc_d = jmp_tgt;
            if (pc_ctrl_jal) begin
                // A full stack overwrites its oldest slot, which is the one top points at.
                push  = 1'b1;
                top_d = top_inc;
                if (cnt_q != DEPTH_C) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
        end else if (pc_ctrl_ret) begin
            if (cnt_q != 5'd0) begin
                pc_d  = ras_mem[top_dec];
                top_d = top_dec;
                cnt_d = cnt_q - 5'd1;
            end else begin
                pc_d   = pc_ctrl_jr_target;
                miss_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pc_ctrl_clk) begin
        if (pc_ctrl_rst) begin
            pc_q   <= RESET_VECTOR;
            epc_q  <= '0;
            cnt_q  <= '0;
            top_q  <= '0;
            miss_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            epc_q  <= epc_d;
            cnt_q  <= cnt_d;
            top_q  <= top_d;
            miss_q <= miss_d;
        end
    end

    always_ff @(posedge pc_ctrl_clk) begin
        if (push && !pc_ctrl_rst) begin
            ras_mem[top_q] <= pc4;
        end
    end

    assign pc_ctrl_out       = pc_q;
    assign pc_ctrl_epc       = epc_q;
    assign pc_ctrl_ras_count = cnt_q;
    assign pc_ctrl_ras_miss  = miss_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl with default parameters.
module tb_pc_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        exc;
    logic        branch;
    logic        jmp;
    logic        jal;
    logic        ret;
    logic [31:0] offset;
    logic [31:0] jr;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [4:0]  cnt;
    logic        miss;

    int tests;
    int failed;

    pc_ctrl dut (
        .pc_ctrl_clk        (clk),
        .pc_ctrl_rst        (rst),
        .pc_ctrl_stall      (stall),
        .pc_ctrl_exc        (exc),
        .pc_ctrl_branch     (branch),
        .pc_ctrl_jmp        (jmp),
        .pc_ctrl_jal        (jal),
        .pc_ctrl_ret        (ret),
        .pc_ctrl_offset_addr(offset),
        .pc_ctrl_jr_target  (jr),
        .pc_ctrl_out        (pc),
        .pc_ctrl_epc        (epc),
        .pc_ctrl_ras_count  (cnt),
        .pc_ctrl_ras_miss   (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        rst = 0; stall = 0; exc = 0; branch = 0;
        jmp = 0; jal = 0; ret = 0; offset = '0; jr = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    task automatic do_jal(input logic [31:0] off);
        idle_in();
        jal = 1; offset = off;
        cyc();
        idle_in();
    endtask

    task automatic do_ret(input logic [31:0] tgt);
        idle_in();
        ret = 1; jr = tgt;
        cyc();
        idle_in();
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        idle_in();
        #2;

        // reset and sequential run
        do_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_miss", 32'(miss), 32'd0);
        cyc(); chk("seq4", pc, 32'h4);
        cyc(); chk("seq8", pc, 32'h8);
        cyc(); chk("seqC", pc, 32'hC);
        cyc(); chk("seq10", pc, 32'h10);

        // backward branch
        branch = 1; offset = 32'hFFFF_FFFE;
        cyc(); idle_in();
        chk("br_back", pc, 32'h0C);

        // empty-stack return lands on jr target
        do_ret(32'hFFFF_FFF8);
        chk("miss_pc", pc, 32'hFFFF_FFF8);
        chk("miss_pulse", 32'(miss), 32'd1);

        // wrap-around branch
        branch = 1; offset = 32'h1;
        cyc(); idle_in();
        chk("br_wrap", pc, 32'h0);
        chk("miss_clr", 32'(miss), 32'd0);

        // jal then ret
        do_ret(32'h1000_0020);
        chk("set_pc", pc, 32'h1000_0020);
        do_jal(32'h40);
        chk("jal_pc", pc, 32'h1000_0100);
        chk("jal_cnt", 32'(cnt), 32'd1);
        do_ret(32'hDEAD_0000);
        chk("ret_pc", pc, 32'h1000_0024);
        chk("ret_cnt", 32'(cnt), 32'd0);
        chk("ret_nomiss", 32'(miss), 32'd0);

        // plain jmp keeps region bits, no push
        jmp = 1; offset = 32'h0300_0010;
        cyc(); idle_in();
        chk("jmp_pc", pc, 32'h1C00_0040);
        chk("jmp_cnt", 32'(cnt), 32'd0);

        // exception under stall
        do_ret(32'h44);
        chk("pc44", pc, 32'h44);
        stall = 1; exc = 1;
        cyc(); idle_in();
        chk("exc_pc", pc, 32'h80);
        chk("exc_epc", epc, 32'h44);

        // stall holds
        stall = 1;
        cyc(); chk("stall1", pc, 32'h80);
        cyc(); chk("stall2", pc, 32'h80);
        idle_in();
        chk("epc_hold", epc, 32'h44);

        // branch beats jal
        branch = 1; jal = 1; offset = 32'h4;
        cyc(); idle_in();
        chk("prio_pc", pc, 32'h94);
        chk("prio_cnt", 32'(cnt), 32'd0);

        // stall beats ret
        stall = 1; ret = 1; jr = 32'h1234;
        cyc(); idle_in();
        chk("stall_ret_pc", pc, 32'h94);
        chk("stall_ret_miss", 32'(miss), 32'd0);

        // overflow of a 4-deep stack
        do_reset();
        chk("ov_start", pc, 32'h0);
        do_jal(32'h40);  chk("ov_j1", pc, 32'h100);
        do_jal(32'h80);  chk("ov_j2", pc, 32'h200);
        do_jal(32'hC0);  chk("ov_j3", pc, 32'h300);
        do_jal(32'h100); chk("ov_j4", pc, 32'h400);
        chk("ov_cnt4", 32'(cnt), 32'd4);
        do_jal(32'h200); chk("ov_j5", pc, 32'h800);
        chk("ov_cnt_sat", 32'(cnt), 32'd4);
        do_ret(32'h8000); chk("ov_r1", pc, 32'h404);
        do_ret(32'h8000); chk("ov_r2", pc, 32'h304);
        do_ret(32'h8000); chk("ov_r3", pc, 32'h204);
        do_ret(32'h8000); chk("ov_r4", pc, 32'h104);
        chk("ov_cnt0", 32'(cnt), 32'd0);
        chk("ov_nomiss", 32'(miss), 32'd0);
        do_ret(32'h8000);
        chk("ov_r5", pc, 32'h8000);
        chk("ov_miss", 32'(miss), 32'd1);
        cyc();
        chk("ov_miss_1cyc", 32'(miss), 32'd0);
        chk("ov_seq", pc, 32'h8004);

        // reset mid-operation
        do_jal(32'h40);
        do_jal(32'h80);
        do_jal(32'hC0);
        chk("mid_cnt3", 32'(cnt), 32'd3);
        rst = 1; exc = 1; stall = 1;
        cyc(); idle_in();
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        chk("mid_rst_epc", epc, 32'h0);
        do_ret(32'h200);
        chk("mid_ret_pc", pc, 32'h200);
        chk("mid_ret_miss", 32'(miss), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
